// File: rtl/riscv_pkg.sv
// riscv_pkg: state encoding shared by the handshake slices of the core
package riscv_pkg;
    typedef enum logic [1:0] {SKID_EMPTY, SKID_BUSY, SKID_FULL} skid_state_e;
endpackage

// File: rtl/riscv_skid_reg.sv
// riscv_skid_reg: load-enabled data register with async active-low clear
module riscv_skid_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] d,
    output logic [DATA_WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (load) q <= d;
endmodule

// File: rtl/riscv_skid_slice.sv
// riscv_skid_slice: two-entry skid buffer registering both valid/data and ready paths
module riscv_skid_slice
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            occupancy
);
    skid_state_e           state, state_d;
    logic                  s_ready_q, s_fire, m_fire;
    logic                  load_main, load_skid, from_skid;
    logic [DATA_WIDTH-1:0] skid_q, main_d;

    assign s_ready   = s_ready_q & ~flush;
    assign m_valid   = (state != SKID_EMPTY) & ~flush;
    assign s_fire    = s_valid & s_ready;
    assign m_fire    = m_valid & m_ready;
    assign occupancy = state == SKID_FULL ? 2'd2 : state == SKID_BUSY ? 2'd1 : 2'd0;
    assign main_d    = from_skid ? skid_q : s_data;

    always_comb begin
        state_d   = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        from_skid = 1'b0;
        if (flush) begin
            state_d = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    load_main = s_fire;
                    state_d   = s_fire ? SKID_BUSY : SKID_EMPTY;
                end
                SKID_BUSY: begin
                    load_main = s_fire & m_fire;
                    load_skid = s_fire & ~m_fire;
                    state_d   = s_fire & ~m_fire ? SKID_FULL :
                                ~s_fire & m_fire ? SKID_EMPTY : SKID_BUSY;
                end
                SKID_FULL: begin
                    load_main = m_fire;
                    from_skid = 1'b1;
                    state_d   = m_fire ? SKID_BUSY : SKID_FULL;
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
    end

    // ready is a pure register: it looks at the next state, never at m_ready directly
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= SKID_EMPTY;
            s_ready_q <= 1'b0;
        end else begin
            state     <= state_d;
            s_ready_q <= state_d != SKID_FULL;
        end

    riscv_skid_reg #(.DATA_WIDTH(DATA_WIDTH)) u_main (
        .clk(clk), .rst_n(rst_n), .load(load_main), .d(main_d), .q(m_data)
    );

    riscv_skid_reg #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk(clk), .rst_n(rst_n), .load(load_skid), .d(s_data), .q(skid_q)
    );
endmodule

// File: tb/tb_riscv_skid_slice.sv
// tb_riscv_skid_slice: directed vectors plus randomized scoreboard run
module tb_riscv_skid_slice;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [1:0]  occupancy;
    int          n_cmp = 0;
    int          n_bad = 0;

    riscv_skid_slice #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        s_valid = v;
        s_data  = d;
        m_ready = r;
        flush   = f;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] sb[$];
    logic [31:0] exp_d, hold_d;
    int          pops, acc, cycles;
    logic        stalled;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", {31'b0, s_ready}, 0);
        chk("rst_m_valid", {31'b0, m_valid}, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_occ", {30'b0, occupancy}, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_s_ready", {31'b0, s_ready}, 1);

        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, i, 1'b1, 1'b0);
            if (i == 1) chk("str_first_valid", {31'b0, m_valid}, 0);
            else begin
                chk("str_valid", {31'b0, m_valid}, 1);
                chk("str_data", m_data, i - 1);
                chk("str_occ", {30'b0, occupancy}, 1);
            end
            tick();
        end
        drive(1'b0, 0, 1'b1, 1'b0);
        chk("str_last", m_data, 32'h10);
        tick();
        drive(1'b0, 0, 1'b0, 1'b0);
        chk("str_empty_occ", {30'b0, occupancy}, 0);

        drive(1'b1, 32'hA, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'hB, 1'b0, 1'b0);
        chk("ss_data_a", m_data, 32'hA);
        chk("ss_ready_b", {31'b0, s_ready}, 1);
        tick();
        drive(1'b1, 32'hC, 1'b1, 1'b0);
        chk("ss_occ2", {30'b0, occupancy}, 2);
        chk("ss_ready_low", {31'b0, s_ready}, 0);
        chk("ss_data_a2", m_data, 32'hA);
        tick();
        drive(1'b1, 32'hC, 1'b1, 1'b0);
        chk("ss_ready_back", {31'b0, s_ready}, 1);
        chk("ss_data_b", m_data, 32'hB);
        tick();
        drive(1'b0, 0, 1'b1, 1'b0);
        chk("ss_data_c", m_data, 32'hC);
        chk("ss_valid_c", {31'b0, m_valid}, 1);
        tick();
        drive(1'b0, 0, 1'b0, 1'b0);
        chk("ss_empty", {31'b0, m_valid}, 0);

        acc = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h21 + (i < 2 ? i : 2), 1'b0, 1'b0);
            if (s_valid && s_ready) acc++;
            if (i >= 2) begin
                chk("ls_ready_low", {31'b0, s_ready}, 0);
                chk("ls_data_const", m_data, 32'h21);
            end
            tick();
        end
        chk("ls_accepted", acc, 2);
        drive(1'b1, 32'h23, 1'b1, 1'b0);
        chk("ls_rel_ready", {31'b0, s_ready}, 0);
        chk("ls_d21", m_data, 32'h21);
        tick();
        drive(1'b1, 32'h23, 1'b1, 1'b0);
        chk("ls_ready_back", {31'b0, s_ready}, 1);
        chk("ls_d22", m_data, 32'h22);
        tick();
        drive(1'b0, 0, 1'b1, 1'b0);
        chk("ls_d23", m_data, 32'h23);
        tick();

        drive(1'b1, 32'h55, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h66, 1'b0, 1'b0);
        tick();
        drive(1'b0, 0, 1'b1, 1'b1);
        chk("fl_m_valid", {31'b0, m_valid}, 0);
        chk("fl_s_ready", {31'b0, s_ready}, 0);
        chk("fl_occ_ungated", {30'b0, occupancy}, 2);
        tick();
        drive(1'b0, 0, 1'b1, 1'b0);
        chk("fl_occ0", {30'b0, occupancy}, 0);
        chk("fl_s_ready1", {31'b0, s_ready}, 1);
        chk("fl_no_valid", {31'b0, m_valid}, 0);

        drive(1'b1, 32'h77, 1'b0, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_m_valid", {31'b0, m_valid}, 0);
        chk("ar_occ", {30'b0, occupancy}, 0);
        chk("ar_m_data", m_data, 0);
        chk("ar_s_ready", {31'b0, s_ready}, 0);
        drive(1'b0, 0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();

        pops = 0;
        cycles = 0;
        stalled = 1'b0;
        hold_d = '0;
        while (pops < 10000 && cycles < 80000) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
            if (stalled) begin
                chk("rnd_hold_valid", {31'b0, m_valid}, 1);
                chk("rnd_hold_data", m_data, hold_d);
            end
            if (s_valid && s_ready) sb.push_back(s_data);
            if (m_valid && m_ready) begin
                if (sb.size() == 0) chk("rnd_underflow", 1, 0);
                else begin
                    exp_d = sb.pop_front();
                    chk("rnd_data", m_data, exp_d);
                end
                pops++;
            end
            stalled = m_valid && !m_ready;
            hold_d = m_data;
            tick();
            cycles++;
        end
        chk("rnd_done", pops, 10000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
